lcd_bus_scheduler: RTL

Shares the single write-only HD44780 LCD bus among NREQ requesters: the power-on initializer, the game-field refresh driver and a status/score overlay writer. Each requester hands over one byte (rs + data) at a time. The scheduler arbitrates, generates the E strobe with setup/hold timing, and holds the bus for the command execution wait before acknowledging. It sits between the requesters and the top-level lcd_* pins and replaces the ad-hoc initializer/driver mux.

---
 rtl/lcd_bus_scheduler_pkg.sv | 24 ++
 rtl/lcd_bus_scheduler_if.sv | 30 +++
 rtl/lcd_rr_arbiter.sv | 60 ++++++
 rtl/lcd_bus_scheduler.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lcd_bus_scheduler_pkg.sv
// Shared types and constants for the HD44780 bus scheduler.
// The FSM state enum, the command codes that need the long busy wait, and the DDRAM line start addresses.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam logic [7:0] LINE_STARTS [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  // Clear display (0x01) and return home (0x02/0x03, bit 0 is don't-care) need the long wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) &&
           ((data == CMD_CLEAR) || ((data & 8'hFE) == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// Requester-side handshake plus LCD pin bundle shared by the scheduler and its clients.
// master = requesters / pin consumer side, slave = the scheduler.
interface lcd_bus_scheduler_if #(
  parameter int NREQ = 3
);
  localparam int ID_W = $clog2(NREQ);

  logic                 init_done;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_rs;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      ack;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic                 lcd_rs;
  logic                 lcd_rw;
  logic                 lcd_e;
  logic [7:0]           lcd_data;

  modport master (
    output init_done, req, req_rs, req_data,
    input  ack, busy, grant_id, lcd_rs, lcd_rw, lcd_e, lcd_data
  );

  modport slave (
    input  init_done, req, req_rs, req_data,
    output ack, busy, grant_id, lcd_rs, lcd_rw, lcd_e, lcd_data
  );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// Requester 0 has fixed top priority; requesters 1..NREQ-1 share the rest round-robin.
// The pointer names the first requester to consider and only moves on a taken grant to a non-zero requester.
module lcd_rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_masked,
  input  logic            advance,
  output logic [ID_W-1:0] winner,
  output logic            valid
);

  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] winner_s;
  logic            valid_s;

  // Priority pick: bit 0 first, then ptr..NREQ-1, then 1..ptr-1
  always_comb begin
    winner_s = '0;
    valid_s  = 1'b0;
    if (req_masked[0]) begin
      winner_s = '0;
      valid_s  = 1'b1;
    end else begin
      for (int j = 1; j < NREQ; j++) begin
        if (!valid_s && req_masked[j] && (ID_W'(j) >= ptr_r)) begin
          winner_s = ID_W'(j);
          valid_s  = 1'b1;
        end else begin
          valid_s  = valid_s;
        end
      end
      for (int j = 1; j < NREQ; j++) begin
        if (!valid_s && req_masked[j] && (ID_W'(j) < ptr_r)) begin
          winner_s = ID_W'(j);
          valid_s  = 1'b1;
        end else begin
          valid_s  = valid_s;
        end
      end
    end
  end

  // Round-robin pointer, wraps within 1..NREQ-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= ID_W'(1);
    end else if (advance && valid_s && (winner_s != '0)) begin
      ptr_r <= (winner_s == ID_W'(NREQ - 1)) ? ID_W'(1) : (winner_s + ID_W'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign winner = winner_s;
  assign valid  = valid_s;

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Time-shares the write-only HD44780 bus: arbitrates one byte at a time, strobes E with
// setup/hold margins, then holds the bus for the controller's execution time before acking.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int SETUP_CYC  = 2,
  parameter int E_HIGH_CYC = 12,
  parameter int HOLD_CYC   = 2,
  parameter int WAIT_SHORT = 2000,
  parameter int WAIT_LONG  = 82000
) (
  input logic               clk,
  input logic               reset,
  lcd_bus_scheduler_if.slave bus
);

  localparam int ID_W    = $clog2(NREQ);
  localparam int CNT_MAX = (WAIT_LONG > E_HIGH_CYC) ? WAIT_LONG : E_HIGH_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic              grant_s;
  logic [NREQ-1:0]   eligible_s;
  logic [NREQ-1:0]   ack_s;
  logic [ID_W-1:0]   arb_winner_s;
  logic              arb_valid_s;

  logic              lcd_e_r;
  logic              lcd_rs_r;
  logic [7:0]        lcd_data_r;
  logic [NREQ-1:0]   ack_r;
  logic              busy_r;
  logic [ID_W-1:0]   grant_id_r;

  // Until the initializer is done only requester 0 may touch the bus
  assign eligible_s = bus.req & (bus.init_done ? {NREQ{1'b1}} : {{(NREQ-1){1'b0}}, 1'b1});

  lcd_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .req_masked (eligible_s),
    .advance    (grant_s),
    .winner     (arb_winner_s),
    .valid      (arb_valid_s)
  );

  // Next-state: each phase loads its length minus one and leaves when the counter hits zero
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          state_s = SETUP;
          cnt_s   = CNT_W'(SETUP_CYC - 1);
          grant_s = 1'b1;
        end else begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      end
      SETUP: begin
        if (cnt_r == '0) begin
          state_s = PULSE;
          cnt_s   = CNT_W'(E_HIGH_CYC - 1);
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_r == '0) begin
          state_s = HOLD;
          cnt_s   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_r == '0) begin
          state_s = WAIT;
          cnt_s   = is_long_cmd(lcd_rs_r, lcd_data_r) ? CNT_W'(WAIT_LONG - 1)
                                                      : CNT_W'(WAIT_SHORT - 1);
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_r == '0) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Ack lands on the final WAIT cycle, addressed to the requester that owns the bus
  always_comb begin
    ack_s = '0;
    if ((state_s == WAIT) && (cnt_s == '0)) begin
      ack_s[grant_id_r] = 1'b1;
    end else begin
      ack_s = '0;
    end
  end

  // State, counter and all pin/handshake outputs registered together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      lcd_e_r    <= 1'b0;
      lcd_rs_r   <= 1'b0;
      lcd_data_r <= 8'h00;
      ack_r      <= '0;
      busy_r     <= 1'b0;
      grant_id_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      lcd_e_r <= (state_s == PULSE);
      busy_r  <= (state_s != IDLE);
      ack_r   <= ack_s;
      if (grant_s) begin
        grant_id_r <= arb_winner_s;
        lcd_rs_r   <= bus.req_rs[arb_winner_s];
        lcd_data_r <= bus.req_data[arb_winner_s];
      end else begin
        grant_id_r <= grant_id_r;
        lcd_rs_r   <= lcd_rs_r;
        lcd_data_r <= lcd_data_r;
      end
    end
  end

  assign bus.ack      = ack_r;
  assign bus.busy     = busy_r;
  assign bus.grant_id = grant_id_r;
  assign bus.lcd_rs   = lcd_rs_r;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = lcd_e_r;
  assign bus.lcd_data = lcd_data_r;

endmodule
